// File: rtl/capture_sequencer.sv
// -----------------------------------------------------------------------------
// capture_sequencer
//
// Purpose: drives the shared write enable and circular write address of the
// five channel RAMs for one capture run. It counts pre-trigger samples until
// the RAM holds enough history to arm the trigger. Once the trigger is taken
// it counts post-trigger samples and then pulses set_capture_done. ram_addr
// always holds the last address written, so the oldest sample sits at
// ram_addr+1 (wrapped).
//
// Optional feature (macro CAPT_FORCE_TRIG_EN): adds a force_trig input.
// force_trig moves PRE_TRIG straight to POST_TRIG even when armed is low.
// Without the macro, the only way out of PRE_TRIG is triggered && armed.
//
// Ports:
//   clk               in   system clock
//   rst_n             in   asynchronous active-low reset
//   capture_en        in   run request (level)
//   capture_done      in   capture-done flag, cleared by host
//   smpl_vld          in   decimated sample strobe, 1 clk wide
//   triggered         in   sticky trigger-detected level
//   trig_pos [LOG2]   in   post-trigger sample count (0 -> 1, >ENTRIES -> ENTRIES)
//   force_trig        in   (CAPT_FORCE_TRIG_EN only) force trigger pulse
//   we                out  channel RAM write enable (combinational)
//   waddr    [LOG2]   out  channel RAM write address
//   ram_addr [LOG2]   out  address of last sample written
//   armed             out  pre-trigger region full
//   set_capture_done  out  1-clk pulse on the final post-trigger write
// -----------------------------------------------------------------------------
module capture_sequencer #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            capture_en,
    input  logic            capture_done,
    input  logic            smpl_vld,
    input  logic            triggered,
    input  logic [LOG2-1:0] trig_pos,
`ifdef CAPT_FORCE_TRIG_EN
    input  logic            force_trig,
`endif
    output logic            we,
    output logic [LOG2-1:0] waddr,
    output logic [LOG2-1:0] ram_addr,
    output logic            armed,
    output logic            set_capture_done
);

    typedef enum logic [1:0] {IDLE, PRE_TRIG, POST_TRIG, DONE} state_t;

    // Counters are one bit wider than the address so they can hold ENTRIES
    // even when ENTRIES == 2**LOG2.
    localparam logic [LOG2:0]   ENT_C     = (LOG2+1)'(ENTRIES);
    localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);

    state_t          state, state_nxt;
    logic [LOG2-1:0] waddr_nxt, ram_addr_nxt;
    logic [LOG2:0]   smpl_cnt, smpl_cnt_nxt;
    logic [LOG2:0]   post_cnt, post_cnt_nxt;
    logic            armed_nxt;
    logic [LOG2:0]   tp_eff;
    logic [LOG2:0]   arm_thr;
    logic            abort;
    logic            go_post;

    // Effective post-trigger count: 0 means "just the trigger sample";
    // anything beyond the RAM depth is clamped to the depth.
    always_comb begin
        if (trig_pos == '0)
            tp_eff = (LOG2+1)'(1);
        else if ({1'b0, trig_pos} > ENT_C)
            tp_eff = ENT_C;
        else
            tp_eff = {1'b0, trig_pos};
    end

    assign arm_thr = ENT_C - tp_eff;
    // A host write to capture_done during a run is treated like dropping
    // capture_en.
    assign abort   = !capture_en || capture_done;

`ifdef CAPT_FORCE_TRIG_EN
    assign go_post = (triggered && armed) || force_trig;
`else
    assign go_post = triggered && armed;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            waddr    <= '0;
            ram_addr <= '0;
            smpl_cnt <= '0;
            post_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            state    <= state_nxt;
            waddr    <= waddr_nxt;
            ram_addr <= ram_addr_nxt;
            smpl_cnt <= smpl_cnt_nxt;
            post_cnt <= post_cnt_nxt;
            armed    <= armed_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        waddr_nxt        = waddr;
        ram_addr_nxt     = ram_addr;
        smpl_cnt_nxt     = smpl_cnt;
        post_cnt_nxt     = post_cnt;
        armed_nxt        = armed;
        we               = 1'b0;
        set_capture_done = 1'b0;

        case (state)
            IDLE: begin
                armed_nxt = 1'b0;
                if (capture_en && !capture_done) begin
                    state_nxt    = PRE_TRIG;
                    waddr_nxt    = '0;
                    smpl_cnt_nxt = '0;
                    post_cnt_nxt = '0;
                    // With a full-depth post region no history is needed,
                    // so the run starts armed.
                    armed_nxt    = (arm_thr == '0);
                end
            end

            PRE_TRIG: begin
                we = smpl_vld;
                if (abort) begin
                    state_nxt = IDLE;
                    armed_nxt = 1'b0;
                end else if (go_post) begin
                    state_nxt = POST_TRIG;
                    // A sample landing in the trigger cycle is post sample #1.
                    if (smpl_vld) begin
                        post_cnt_nxt = (LOG2+1)'(1);
                        if (tp_eff == (LOG2+1)'(1)) begin
                            set_capture_done = 1'b1;
                            state_nxt        = DONE;
                            armed_nxt        = 1'b0;
                        end
                    end
                end else begin
                    if (smpl_vld && (smpl_cnt != ENT_C))
                        smpl_cnt_nxt = smpl_cnt + 1'b1;
                    armed_nxt = (smpl_cnt_nxt >= arm_thr);
                end
            end

            POST_TRIG: begin
                we = smpl_vld;
                if (abort) begin
                    state_nxt = IDLE;
                    armed_nxt = 1'b0;
                end else if (smpl_vld) begin
                    post_cnt_nxt = post_cnt + 1'b1;
                    if (post_cnt_nxt == tp_eff) begin
                        set_capture_done = 1'b1;
                        state_nxt        = DONE;
                        armed_nxt        = 1'b0;
                    end
                end
            end

            DONE: begin
                if (!capture_done && !capture_en)
                    state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase

        if (we) begin
            ram_addr_nxt = waddr;
            waddr_nxt    = (waddr == LAST_ADDR) ? '0 : waddr + 1'b1;
        end
    end

endmodule
